// File: rtl/exe_mem.sv
// EX/MEM pipeline register: captures execute-stage results and controls for the
// memory stage, with stall/flush handling, forwarding/branch derivation and a bubble counter.
module exe_mem #(
  parameter int DATA_W = 64,
  parameter int PC_W   = 12,
  parameter int REG_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              e_valid,
  input  logic [DATA_W-1:0] e_alu_result,
  input  logic              e_zero,
  input  logic [DATA_W-1:0] e_store_data,
  input  logic [PC_W-1:0]   e_br_target,
  input  logic [REG_W-1:0]  e_wr_reg,
  input  logic              e_mem2reg,
  input  logic              e_ctrl_regwr,
  input  logic              e_memrd,
  input  logic              e_memwr,
  input  logic              e_branch,
  input  logic              stall,
  input  logic              flush,
  output logic              em_valid,
  output logic [DATA_W-1:0] em_alu_result,
  output logic              em_zero,
  output logic [DATA_W-1:0] em_store_data,
  output logic [PC_W-1:0]   em_br_target,
  output logic [REG_W-1:0]  em_wr_reg,
  output logic              em_mem2reg,
  output logic              em_ctrl_regwr,
  output logic              em_memrd,
  output logic              em_memwr,
  output logic              em_branch,
  output logic              em_pc_src,
  output logic              em_fwd_en,
  output logic [CNT_W-1:0]  em_bubble_cnt
);

  logic bubble_in;
  logic cnt_sat;

  // A slot becomes a bubble either by flush or by loading a non-valid instruction.
  assign bubble_in = flush | ~e_valid;
  assign cnt_sat   = &em_bubble_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      em_valid      <= 1'b0;
      em_alu_result <= '0;
      em_zero       <= 1'b0;
      em_store_data <= '0;
      em_br_target  <= '0;
      em_wr_reg     <= '0;
      em_mem2reg    <= 1'b0;
      em_ctrl_regwr <= 1'b0;
      em_memrd      <= 1'b0;
      em_memwr      <= 1'b0;
      em_branch     <= 1'b0;
    end else if (!stall) begin
      em_valid      <= e_valid;
      em_alu_result <= e_alu_result;
      em_zero       <= e_zero;
      em_store_data <= e_store_data;
      em_br_target  <= e_br_target;
      em_wr_reg     <= e_wr_reg;
      // Controls are gated so a non-valid slot can never write memory or registers.
      em_mem2reg    <= e_valid & e_mem2reg;
      em_ctrl_regwr <= e_valid & e_ctrl_regwr;
      em_memrd      <= e_valid & e_memrd;
      em_memwr      <= e_valid & e_memwr;
      em_branch     <= e_valid & e_branch;
    end
  end

  // Flush inserts a bubble even when stalled, so it is counted even under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      em_bubble_cnt <= '0;
    end else if ((flush || !stall) && bubble_in && !cnt_sat) begin
      em_bubble_cnt <= em_bubble_cnt + 1'b1;
    end
  end

  assign em_pc_src = em_valid & em_branch & em_zero;
  assign em_fwd_en = em_valid & em_ctrl_regwr & (em_wr_reg != '0);

endmodule

// File: tb/tb_exe_mem.sv
// Bench for exe_mem: a default-width instance and a 4-bit-counter instance share
// stimulus; a behavioural model is compared every cycle, plus directed literal checks.
module tb_exe_mem;

  logic        clk = 1'b0;
  logic        rst, e_valid, e_zero, e_mem2reg, e_ctrl_regwr, e_memrd, e_memwr, e_branch;
  logic        stall, flush;
  logic [63:0] e_alu_result, e_store_data;
  logic [11:0] e_br_target;
  logic [5:0]  e_wr_reg;

  // Instance a: CNT_W=16, instance b: CNT_W=4.
  logic        a_valid, a_zero, a_m2r, a_rw, a_mr, a_mw, a_br, a_pc_src, a_fwd;
  logic [63:0] a_alu, a_sd;
  logic [11:0] a_tgt;
  logic [5:0]  a_wr;
  logic [15:0] a_cnt;
  logic        b_valid, b_zero, b_m2r, b_rw, b_mr, b_mw, b_br, b_pc_src, b_fwd;
  logic [63:0] b_alu, b_sd;
  logic [11:0] b_tgt;
  logic [5:0]  b_wr;
  logic [3:0]  b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  exe_mem u_a (
    .clk(clk), .rst(rst), .e_valid(e_valid), .e_alu_result(e_alu_result), .e_zero(e_zero),
    .e_store_data(e_store_data), .e_br_target(e_br_target), .e_wr_reg(e_wr_reg),
    .e_mem2reg(e_mem2reg), .e_ctrl_regwr(e_ctrl_regwr), .e_memrd(e_memrd), .e_memwr(e_memwr),
    .e_branch(e_branch), .stall(stall), .flush(flush),
    .em_valid(a_valid), .em_alu_result(a_alu), .em_zero(a_zero), .em_store_data(a_sd),
    .em_br_target(a_tgt), .em_wr_reg(a_wr), .em_mem2reg(a_m2r), .em_ctrl_regwr(a_rw),
    .em_memrd(a_mr), .em_memwr(a_mw), .em_branch(a_br), .em_pc_src(a_pc_src),
    .em_fwd_en(a_fwd), .em_bubble_cnt(a_cnt)
  );

  exe_mem #(.CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .e_valid(e_valid), .e_alu_result(e_alu_result), .e_zero(e_zero),
    .e_store_data(e_store_data), .e_br_target(e_br_target), .e_wr_reg(e_wr_reg),
    .e_mem2reg(e_mem2reg), .e_ctrl_regwr(e_ctrl_regwr), .e_memrd(e_memrd), .e_memwr(e_memwr),
    .e_branch(e_branch), .stall(stall), .flush(flush),
    .em_valid(b_valid), .em_alu_result(b_alu), .em_zero(b_zero), .em_store_data(b_sd),
    .em_br_target(b_tgt), .em_wr_reg(b_wr), .em_mem2reg(b_m2r), .em_ctrl_regwr(b_rw),
    .em_memrd(b_mr), .em_memwr(b_mw), .em_branch(b_br), .em_pc_src(b_pc_src),
    .em_fwd_en(b_fwd), .em_bubble_cnt(b_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the memory stage should hold after each edge.
  typedef struct packed {
    logic        v;
    logic [63:0] alu;
    logic        z;
    logic [63:0] sd;
    logic [11:0] tgt;
    logic [5:0]  wr;
    logic        m2r, rw, mr, mw, br;
  } stage_t;

  stage_t m;
  int     c16, c4;
  bit     model_ok = 0;

  always @(posedge clk) begin
    if (rst) begin
      m = '0; c16 = 0; c4 = 0; model_ok = 1;
    end else if (flush) begin
      m = '0;
      c16 = (c16 < 65535) ? c16 + 1 : c16;
      c4  = (c4 < 15) ? c4 + 1 : c4;
    end else if (!stall) begin
      m.v   = e_valid;
      m.alu = e_alu_result;
      m.z   = e_zero;
      m.sd  = e_store_data;
      m.tgt = e_br_target;
      m.wr  = e_wr_reg;
      m.m2r = e_valid && e_mem2reg;
      m.rw  = e_valid && e_ctrl_regwr;
      m.mr  = e_valid && e_memrd;
      m.mw  = e_valid && e_memwr;
      m.br  = e_valid && e_branch;
      if (!e_valid) begin
        c16 = (c16 < 65535) ? c16 + 1 : c16;
        c4  = (c4 < 15) ? c4 + 1 : c4;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("a_stage", {a_valid, a_alu, a_zero, a_sd, a_tgt, a_wr, a_m2r, a_rw, a_mr, a_mw, a_br}
                       ^ m, '0);
      check("b_stage", {b_valid, b_alu, b_zero, b_sd, b_tgt, b_wr, b_m2r, b_rw, b_mr, b_mw, b_br}
                       ^ m, '0);
      check("a_pc_src", a_pc_src, m.v && m.br && m.z);
      check("b_pc_src", b_pc_src, m.v && m.br && m.z);
      check("a_fwd_en", a_fwd, m.v && m.rw && (m.wr != 0));
      check("b_fwd_en", b_fwd, m.v && m.rw && (m.wr != 0));
      check("a_bubble_cnt", a_cnt, c16);
      check("b_bubble_cnt", b_cnt, c4);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    e_valid = 0; e_alu_result = '0; e_zero = 0; e_store_data = '0; e_br_target = '0;
    e_wr_reg = '0; e_mem2reg = 0; e_ctrl_regwr = 0; e_memrd = 0; e_memwr = 0; e_branch = 0;
    stall = 0; flush = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    stall = 1; flush = 1;  // reset must dominate both
    step(); step();
    check("rst_valid", a_valid, 0);
    check("rst_alu", a_alu, 0);
    check("rst_cnt", a_cnt, 0);
    rst = 0; stall = 0; flush = 0;

    // Reset then load
    e_valid = 1; e_alu_result = 64'h0123_4567_89AB_CDEF; e_wr_reg = 6'd5; e_ctrl_regwr = 1;
    e_store_data = 64'hDEAD_BEEF_0000_1111;
    step();
    check("load_alu", a_alu, 64'h0123_4567_89AB_CDEF);
    check("load_wr_reg", a_wr, 5);
    check("load_fwd_en", a_fwd, 1);
    check("load_cnt", a_cnt, 0);

    // Stall hold
    e_alu_result = 64'hAA;
    step();
    check("pre_stall_alu", a_alu, 64'hAA);
    stall = 1; e_alu_result = 64'hBB;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold_alu", a_alu, 64'hAA);
      check("stall_hold_cnt", a_cnt, 0);
    end
    stall = 0;
    step();
    check("post_stall_alu", a_alu, 64'hBB);

    // Flush wins over stall
    stall = 1; flush = 1; e_memwr = 1; e_valid = 1;
    step();
    check("flush_valid", a_valid, 0);
    check("flush_memwr", a_mw, 0);
    check("flush_alu", a_alu, 0);
    check("flush_cnt", a_cnt, 1);
    clear_inputs();

    // Branch select
    e_valid = 1; e_branch = 1; e_zero = 1; e_br_target = 12'h040;
    step();
    check("br_taken_pc_src", a_pc_src, 1);
    check("br_target", a_tgt, 12'h040);
    e_zero = 0;
    step();
    check("br_not_taken_pc_src", a_pc_src, 0);
    e_zero = 1; e_valid = 0;
    step();
    check("br_invalid_pc_src", a_pc_src, 0);
    check("br_invalid_branch", a_br, 0);
    check("br_invalid_cnt", a_cnt, 2);
    clear_inputs();

    // Forwarding gate
    e_valid = 1; e_ctrl_regwr = 1; e_wr_reg = 6'd0;
    step();
    check("fwd_r0", a_fwd, 0);
    e_wr_reg = 6'd31;
    step();
    check("fwd_r31", a_fwd, 1);
    clear_inputs();

    // Counter saturation: count was 2, 20 bubbles -> 4-bit saturates, 16-bit reaches 22
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt4", b_cnt, 4'hF);
    check("nosat_cnt16", a_cnt, 22);
    step();
    check("sat_hold_cnt4", b_cnt, 4'hF);
    rst = 1; e_valid = 1; e_alu_result = 64'h55; e_memwr = 1;
    step();
    check("mid_rst_cnt4", b_cnt, 0);
    check("mid_rst_valid", b_valid, 0);
    check("mid_rst_alu", b_alu, 0);
    check("mid_rst_memwr", b_mw, 0);
    rst = 0; clear_inputs();
    step();
    check("post_rst_cnt4", b_cnt, 1);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_mem.md
Name: exe_mem

Overview:
- Pipeline register between the execute stage and the data-memory stage of the 5-stage core.
- Captures the ALU result, store data, branch target, destination register and the memory/writeback control bits produced in execute.
- Presents them to the memory stage one cycle later and supports stall (hold), flush (bubble insertion) and a valid bit.
- Derives the branch-taken select and the EX/MEM forwarding-enable seen by the forwarding unit, and keeps a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 64, width of ALU result and store data
- PC_W, 12, width of branch target / PC
- REG_W, 6, width of destination register index
- CNT_W, 16, width of bubble counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- e_valid  input  1  execute stage holds a real instruction
- e_alu_result  input  DATA_W  ALU output
- e_zero  input  1  ALU zero flag
- e_store_data  input  DATA_W  forwarded rs2 value for stores
- e_br_target  input  PC_W  computed branch target
- e_wr_reg  input  REG_W  destination register index
- e_mem2reg  input  1  writeback selects memory data
- e_ctrl_regwr  input  1  register write enable
- e_memrd  input  1  memory read
- e_memwr  input  1  memory write
- e_branch  input  1  instruction is a branch
- stall  input  1  hold all stage state
- flush  input  1  replace incoming instruction with a bubble
- em_valid  output  1  registered valid
- em_alu_result  output  DATA_W  registered ALU result
- em_zero  output  1  registered zero flag
- em_store_data  output  DATA_W  registered store data
- em_br_target  output  PC_W  registered branch target
- em_wr_reg  output  REG_W  registered destination
- em_mem2reg, em_ctrl_regwr, em_memrd, em_memwr, em_branch  output  1 each  registered controls
- em_pc_src  output  1  branch taken: em_valid & em_branch & em_zero (combinational from registers)
- em_fwd_en  output  1  em_valid & em_ctrl_regwr & (em_wr_reg != 0)
- em_bubble_cnt  output  CNT_W  count of cycles em_valid was 0 after a clock edge

Behaviour:
- Clock `clk`; reset `rst` is synchronous, active-high. Single clock domain.
- Update priority per rising edge: rst > flush > stall > normal load.
- rst: all registered outputs cleared to 0 (valid, data, target, wr_reg, all controls); em_bubble_cnt = 0.
- flush (rst=0): em_valid and all five control bits cleared to 0; em_alu_result, em_store_data, em_br_target, em_wr_reg, em_zero cleared to 0. flush wins over stall when both are high.
- stall (rst=0, flush=0): every register holds its value; em_bubble_cnt also holds.
- Normal load: every em_* register takes its e_* input.
  - When e_valid=0, the control bits are loaded as 0, regardless of their inputs, so a non-valid slot can never write memory or registers.
- Latency: exactly 1 cycle from input to em_* output. em_pc_src and em_fwd_en are valid in the same cycle as the registers they derive from.
- No X ever appears on any output after the first reset; bubbles are zero-filled.
- Bubble counter:
  - On each non-stalled, non-reset edge, increment if the value being loaded into em_valid is 0 (flush, or load with e_valid=0).
  - Saturates at all-ones (no wrap).
- em_pc_src is asserted for exactly one cycle per taken branch unless stalled; while stalled it persists. Upstream must flush on em_pc_src.
- Reset mid-stall or mid-flush: rst dominates; the next cycle behaves as a normal load.
- Widths: inputs are registered unmodified; no sign/zero extension is performed here.

Test Plan:
- Reset then load: rst=1 for 2 cycles, release; e_valid=1, e_alu_result=64'h0123_4567_89AB_CDEF, e_wr_reg=5, e_ctrl_regwr=1 -> next cycle em_alu_result matches, em_wr_reg=5, em_fwd_en=1, em_bubble_cnt=0.
- Stall hold: load e_alu_result=64'hAA, then stall=1 for 3 cycles while inputs change to 64'hBB -> em_alu_result stays 64'hAA for all 3 cycles; em_bubble_cnt unchanged; 64'hBB appears 1 cycle after stall drops.
- Flush priority: stall=1, flush=1, e_memwr=1, e_valid=1 -> next cycle em_valid=0, em_memwr=0, em_alu_result=0, em_bubble_cnt increments by 1.
- Branch select: e_valid=1, e_branch=1, e_zero=1, e_br_target=12'h040 -> next cycle em_pc_src=1, em_br_target=12'h040. Same stimulus with e_zero=0 -> em_pc_src=0. Same stimulus with e_valid=0 -> em_pc_src=0, em_branch=0.
- Forwarding gate: e_valid=1, e_ctrl_regwr=1, e_wr_reg=0 -> em_fwd_en=0. With e_wr_reg=6'd31 -> em_fwd_en=1.
- Counter saturation (CNT_W=4): hold e_valid=0 for 20 cycles -> em_bubble_cnt reaches 4'hF and stays. Then assert rst for 1 cycle mid-sequence -> em_bubble_cnt=0 and all outputs 0 on the next cycle.
